// File: rtl/timing_pkg.sv
// Shared types and constants for the LVDA timing phase generator.
package timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] PH_W = 2'd0;
  localparam logic [1:0] PH_X = 2'd1;
  localparam logic [1:0] PH_Y = 2'd2;
  localparam logic [1:0] PH_Z = 2'd3;

  localparam int DEF_PULSE_W = 4;
  localparam int DEF_GAP_W   = 2;

endpackage

// File: rtl/timing_phase_ctr.sv
// Loadable down-counter; tc flags the last cycle of a loaded interval and
// the count holds at zero until the next load.
module timing_phase_ctr #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!tc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/timing_phase_gen.sv
// Four-phase non-overlapping WDA/XDA/YDA/ZDA generator with run/stop,
// SYNC resynchronisation, frame strobe and frame counter.
module timing_phase_gen
  import timing_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int FCW     = 8
) (
  input  logic           SIM_CLK,
  input  logic           SIM_RST,
  input  logic           RUN,
  input  logic           SYNC,
  input  logic           CLR_ERR,
  output logic           WDA,
  output logic           XDA,
  output logic           YDA,
  output logic           ZDA,
  output logic [1:0]     PHASE,
  output logic           FRAME_STB,
  output logic [FCW-1:0] FRAME_CNT,
  output logic           SYNC_ERR,
  output state_t         DBG_STATE
);

  localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

  state_t        state, nxt_state;
  logic [1:0]    ph, nxt_ph;
  logic          no_stb, nxt_no_stb;
  logic          cnt_load;
  logic [CW-1:0] cnt_val, cnt;
  logic          tc;
  logic          frame_end, set_err, nxt_zero, stb_next;
  logic [3:0]    drive;

  timing_phase_ctr #(.CW(CW)) u_ctr (
    .clk      (SIM_CLK),
    .rst_n    (SIM_RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .count    (cnt),
    .tc       (tc)
  );

  assign frame_end = (state == GAP) && (ph == PH_Z) && tc;

  // Leaving IDLE passes through a one-cycle frame-end GAP(Z) with the strobe
  // suppressed; this gives the one-cycle start latency and reuses the resync path.
  always_comb begin
    nxt_state  = state;
    nxt_ph     = ph;
    nxt_no_stb = no_stb;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (RUN) begin
          nxt_state  = GAP;
          nxt_ph     = PH_Z;
          nxt_no_stb = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      PULSE: begin
        if (tc) begin
          nxt_state = GAP;
          cnt_load  = 1'b1;
          cnt_val   = GAP_LD;
        end
      end
      GAP: begin
        if (tc) begin
          nxt_no_stb = 1'b0;
          if (ph != PH_Z) begin
            nxt_state = PULSE;
            nxt_ph    = ph + 2'd1;
            cnt_load  = 1'b1;
            cnt_val   = PULSE_LD;
          end else if (RUN) begin
            nxt_state = PULSE;
            nxt_ph    = PH_W;
            cnt_load  = 1'b1;
            cnt_val   = PULSE_LD;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    if (SYNC && (state != IDLE) && !frame_end) begin
      nxt_state  = GAP;
      nxt_ph     = PH_Z;
      nxt_no_stb = 1'b1;
      cnt_load   = 1'b1;
      cnt_val    = GAP_LD;
      set_err    = 1'b1;
    end
  end

  // Outputs are registered from the next-state decode so they line up with state.
  assign nxt_zero = cnt_load ? (cnt_val == '0) : (cnt <= CW'(1));
  assign stb_next = (nxt_state == GAP) && (nxt_ph == PH_Z) && nxt_zero && !nxt_no_stb;

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state  <= IDLE;
      ph     <= PH_W;
      no_stb <= 1'b0;
    end else begin
      state  <= nxt_state;
      ph     <= nxt_ph;
      no_stb <= nxt_no_stb;
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      drive     <= '0;
      PHASE     <= PH_W;
      FRAME_STB <= 1'b0;
      FRAME_CNT <= '0;
      SYNC_ERR  <= 1'b0;
    end else begin
      drive     <= (nxt_state == PULSE) ? (4'b0001 << nxt_ph) : 4'b0000;
      FRAME_STB <= stb_next;
      if (nxt_state == PULSE) PHASE <= nxt_ph;
      if (stb_next) FRAME_CNT <= FRAME_CNT + 1'b1;
      if (set_err) SYNC_ERR <= 1'b1;
      else if (CLR_ERR) SYNC_ERR <= 1'b0;
    end
  end

  assign WDA       = drive[0];
  assign XDA       = drive[1];
  assign YDA       = drive[2];
  assign ZDA       = drive[3];
  assign DBG_STATE = state;

endmodule
